mips_bytemem: RTL and testbench

Byte-wide memory responder serving the multicycle `mips` core's `memread`/`memwrite`/`adr`/`writedata`/`memdata` interface. It returns registered read bytes and accepts core byte writes. A built-in loader takes 32-bit instruction words over a valid/ready handshake and writes them big-endian, one byte per cycle, so a bench or boot path can place programs without driving bytes by hand.

---
 rtl/mips_bytemem.sv | 150 +++++++++++++++
 tb/tb_mips_bytemem.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bytemem.sv
// Byte-wide memory responder for the multicycle mips core. It provides a
// registered read port, a core byte-write port, and a word loader that
// writes 32-bit words big-endian, one byte per cycle, with priority over
// core writes.
module mips_bytemem #(
    parameter int WIDTH = 8,
    parameter int ADDRW = 8,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [ADDRW-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_word,
    input  logic [ADDRW-1:0] ld_addr,
    output logic             ld_busy,
    output logic             oob_err,
    output logic             wr_drop
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRW:0] DEPTH_L = (ADDRW+1)'(DEPTH);

    typedef enum logic [2:0] {LD_IDLE, LD_B0, LD_B1, LD_B2, LD_B3} ld_state_e;

    ld_state_e        state_q, state_d;
    logic [31:0]      word_q, word_d;
    logic [ADDRW-1:0] base_q, base_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] memdata_q;
    logic             oob_q, drop_q;

    logic [1:0]       lw_off;
    logic [WIDTH-1:0] lw_byte;
    logic [ADDRW-1:0] lw_addr;
    logic             core_in, ld_in;
    logic             we;
    logic [IDXW-1:0]  widx;
    logic [WIDTH-1:0] wdat;

    // Loader state register plus latched word and base address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LD_IDLE;
            word_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            base_q  <= base_d;
        end
    end

    // Loader next state, handshake outputs and the byte to write this cycle.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        base_d   = base_q;
        ld_ready = 1'b0;
        ld_busy  = 1'b1;
        lw_off   = 2'd0;
        lw_byte  = WIDTH'(word_q[31:24]);
        unique case (state_q)
            LD_IDLE: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b0;
                if (ld_valid) begin
                    state_d = LD_B0;
                    word_d  = ld_word;
                    base_d  = ld_addr;
                end
            end
            LD_B0: begin
                state_d = LD_B1;
            end
            LD_B1: begin
                state_d = LD_B2;
                lw_off  = 2'd1;
                lw_byte = WIDTH'(word_q[23:16]);
            end
            LD_B2: begin
                state_d = LD_B3;
                lw_off  = 2'd2;
                lw_byte = WIDTH'(word_q[15:8]);
            end
            LD_B3: begin
                state_d = LD_IDLE;
                lw_off  = 2'd3;
                lw_byte = WIDTH'(word_q[7:0]);
            end
            default: state_d = LD_IDLE;
        endcase
    end

    // Single write port: a busy loader owns it, otherwise the core may write.
    always_comb begin
        lw_addr = base_q + ADDRW'(lw_off);
        core_in = ({1'b0, adr} < DEPTH_L);
        ld_in   = ({1'b0, lw_addr} < DEPTH_L);
        we      = 1'b0;
        widx    = '0;
        wdat    = '0;
        if (ld_busy) begin
            we   = ld_in;
            widx = lw_addr[IDXW-1:0];
            wdat = lw_byte;
        end else if (memwrite) begin
            we   = core_in;
            widx = adr[IDXW-1:0];
            wdat = writedata;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdat;
        end
    end

    // Registered read byte (old data on same-address write) and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memdata_q <= '0;
            oob_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            if (memread) begin
                memdata_q <= core_in ? mem_q[adr[IDXW-1:0]] : '0;
            end
            if ((memread || memwrite) && !core_in) begin
                oob_q <= 1'b1;
            end
            if (memwrite && ld_busy) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign memdata = memdata_q;
    assign oob_err = oob_q;
    assign wr_drop = drop_q;

endmodule

// File: tb/tb_mips_bytemem.sv
// Bench for mips_bytemem: two instances (DEPTH 256 and 16) share stimulus and
// are compared against a byte-array / pending-byte-queue reference model.
module tb_mips_bytemem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, memread, memwrite, ld_valid;
    logic [7:0]  adr, writedata, ld_addr;
    logic [31:0] ld_word;

    logic [1:0][7:0] md_w;
    logic [1:0]      rdy_w, busy_w, oob_w, drop_w;

    mips_bytemem #(.WIDTH(8), .ADDRW(8), .DEPTH(256)) u_big (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .adr(adr), .writedata(writedata), .memdata(md_w[0]),
        .ld_valid(ld_valid), .ld_ready(rdy_w[0]), .ld_word(ld_word),
        .ld_addr(ld_addr), .ld_busy(busy_w[0]), .oob_err(oob_w[0]),
        .wr_drop(drop_w[0])
    );

    mips_bytemem #(.WIDTH(8), .ADDRW(8), .DEPTH(16)) u_small (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .adr(adr), .writedata(writedata), .memdata(md_w[1]),
        .ld_valid(ld_valid), .ld_ready(rdy_w[1]), .ld_word(ld_word),
        .ld_addr(ld_addr), .ld_busy(busy_w[1]), .oob_err(oob_w[1]),
        .wr_drop(drop_w[1])
    );

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference model: per-instance byte arrays, plus a queue of loader bytes
    // still to be written (one retires per clock edge).
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } ld_byte_t;

    ld_byte_t   ldq[$];
    int         dep[2] = '{256, 16};
    logic [7:0] mmem[2][256];
    bit         mknown[2][256];
    logic [7:0] mmd[2];
    bit         mmd_known[2];
    bit         moob[2];
    bit         mdrop[2];

    task automatic model_reset();
        ldq.delete();
        for (int k = 0; k < 2; k++) begin
            mmd[k] = 8'h00;
            mmd_known[k] = 1'b1;
            moob[k] = 1'b0;
            mdrop[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit       busy;
        bit       acc;
        bit       inr;
        ld_byte_t e;
        busy = (ldq.size() != 0);
        acc  = ld_valid && !busy;
        for (int k = 0; k < 2; k++) begin
            inr = (int'(adr) < dep[k]);
            if (memread) begin
                mmd[k] = inr ? mmem[k][adr] : 8'h00;
                mmd_known[k] = inr ? mknown[k][adr] : 1'b1;
            end
            if ((memread || memwrite) && !inr) moob[k] = 1'b1;
            if (memwrite && busy) mdrop[k] = 1'b1;
            if (memwrite && !busy && inr) begin
                mmem[k][adr] = writedata;
                mknown[k][adr] = 1'b1;
            end
        end
        if (busy) begin
            e = ldq.pop_front();
            for (int k = 0; k < 2; k++) begin
                if (int'(e.a) < dep[k]) begin
                    mmem[k][e.a] = e.d;
                    mknown[k][e.a] = 1'b1;
                end
            end
        end
        if (acc) begin
            for (int i = 0; i < 4; i++) begin
                e.a = ld_addr + 8'(i);
                e.d = ld_word[31-8*i -: 8];
                ldq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [31:0] w, input logic [7:0] a, output int acc_at);
        bit rdy;
        int n;
        n = 0;
        acc_at = -1;
        ld_word = w;
        ld_addr = a;
        ld_valid = 1'b1;
        while (acc_at < 0 && n < 20) begin
            rdy = (ldq.size() == 0);
            tick();
            n++;
            if (rdy) acc_at = edge_n;
        end
        ld_valid = 1'b0;
        ld_word = $urandom;
        ld_addr = 8'($urandom);
        if (acc_at < 0) begin
            checks++; errors++;
            $display("FAIL load_accept_timeout: got no accept, required accept within 20 cycles");
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ldq.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        if (ldq.size() != 0) begin
            checks++; errors++;
            $display("FAIL idle_timeout: loader model still busy after 10 cycles");
        end
    endtask

    task automatic do_read(input logic [7:0] a);
        memread = 1'b1;
        adr = a;
        tick();
        memread = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        memwrite = 1'b1;
        adr = a;
        writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic test_reset();
        #17;
        for (int k = 0; k < 2; k++) begin
            checks += 5;
            if (md_w[k] !== 8'h00) begin errors++; $display("FAIL reset_memdata[%0d]: got %h required 00", k, md_w[k]); end
            if (rdy_w[k] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b required 1", k, rdy_w[k]); end
            if (busy_w[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b required 0", k, busy_w[k]); end
            if (oob_w[k] !== 1'b0) begin errors++; $display("FAIL reset_oob[%0d]: got %b required 0", k, oob_w[k]); end
            if (drop_w[k] !== 1'b0) begin errors++; $display("FAIL reset_drop[%0d]: got %b required 0", k, drop_w[k]); end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_load_basic();
        int         t;
        int         cnt;
        logic [7:0] exp_b[4];
        exp_b = '{8'h20, 8'h00, 8'h18, 8'h0A};
        do_load(32'h2000180A, 8'h00, t);
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            if (rdy_w[0] !== 1'b0) break;
            checks++;
            if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL busy_during_load: got %b required 1", busy_w[0]); end
            cnt++;
            tick();
        end
        checks += 2;
        if (cnt !== 4) begin errors++; $display("FAIL ready_low_cycles: got %0d required 4", cnt); end
        if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL busy_after_load: got %b required 0", busy_w[0]); end
        for (int i = 0; i < 4; i++) begin
            do_read(8'(i));
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (md_w[k] !== exp_b[i]) begin errors++; $display("FAIL load_byte[%0d][%0d]: got %h required %h", k, i, md_w[k], exp_b[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int         t1, t2;
        logic [7:0] exp_b[4];
        exp_b = '{8'h00, 8'h63, 8'h18, 8'h20};
        do_load(32'h00631820, 8'h04, t1);
        do_load(32'h00631820, 8'h08, t2);
        checks++;
        if (t2 - t1 !== 5) begin errors++; $display("FAIL b2b_spacing: got %0d required 5", t2 - t1); end
        wait_idle();
        for (int i = 4; i < 12; i++) begin
            do_read(8'(i));
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (md_w[k] !== exp_b[i % 4]) begin errors++; $display("FAIL b2b_byte[%0d][%0d]: got %h required %h", k, i, md_w[k], exp_b[i % 4]); end
            end
        end
    endtask

    task automatic test_write_drop();
        int t;
        checks++;
        if (drop_w[0] !== 1'b0) begin errors++; $display("FAIL drop_initial: got %b required 0", drop_w[0]); end
        do_load(32'h2000180A, 8'h00, t);
        tick();
        do_write(8'h03, 8'h5A);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (drop_w[k] !== 1'b1) begin errors++; $display("FAIL drop_set[%0d]: got %b required 1", k, drop_w[k]); end
        end
        wait_idle();
        do_read(8'h03);
        checks++;
        if (md_w[0] !== 8'h0A) begin errors++; $display("FAIL drop_byte3: got %h required 0A", md_w[0]); end
        do_write(8'h03, 8'h5A);
        do_read(8'h03);
        checks += 2;
        if (md_w[0] !== 8'h5A) begin errors++; $display("FAIL idle_write: got %h required 5A", md_w[0]); end
        if (drop_w[0] !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b required 1", drop_w[0]); end
    endtask

    task automatic test_wrap();
        int t;
        do_load(32'hAABBCCDD, 8'h0E, t);
        wait_idle();
        checks++;
        if (oob_w[1] !== 1'b0) begin errors++; $display("FAIL loader_no_oob_0E: got %b required 0", oob_w[1]); end
        do_read(8'h0E);
        checks += 2;
        if (md_w[1] !== 8'hAA) begin errors++; $display("FAIL small_0E: got %h required AA", md_w[1]); end
        if (md_w[0] !== 8'hAA) begin errors++; $display("FAIL big_0E: got %h required AA", md_w[0]); end
        do_read(8'h0F);
        checks++;
        if (md_w[1] !== 8'hBB) begin errors++; $display("FAIL small_0F: got %h required BB", md_w[1]); end
        do_load(32'h99887766, 8'hFE, t);
        wait_idle();
        checks++;
        if (oob_w[1] !== 1'b0) begin errors++; $display("FAIL loader_no_oob_FE: got %b required 0", oob_w[1]); end
        do_read(8'h00);
        checks += 2;
        if (md_w[0] !== 8'h77) begin errors++; $display("FAIL wrap_big_00: got %h required 77", md_w[0]); end
        if (md_w[1] !== 8'h77) begin errors++; $display("FAIL wrap_small_00: got %h required 77", md_w[1]); end
        do_read(8'h01);
        checks++;
        if (md_w[0] !== 8'h66) begin errors++; $display("FAIL wrap_big_01: got %h required 66", md_w[0]); end
        do_read(8'hFE);
        checks++;
        if (md_w[0] !== 8'h99) begin errors++; $display("FAIL wrap_big_FE: got %h required 99", md_w[0]); end
        do_read(8'hFF);
        checks++;
        if (md_w[0] !== 8'h88) begin errors++; $display("FAIL wrap_big_FF: got %h required 88", md_w[0]); end
    endtask

    task automatic test_oob();
        do_read(8'h20);
        checks += 3;
        if (md_w[1] !== 8'h00) begin errors++; $display("FAIL oob_read_data: got %h required 00", md_w[1]); end
        if (oob_w[1] !== 1'b1) begin errors++; $display("FAIL oob_small_flag: got %b required 1", oob_w[1]); end
        if (oob_w[0] !== 1'b0) begin errors++; $display("FAIL oob_big_flag: got %b required 0", oob_w[0]); end
    endtask

    task automatic test_reset_midload();
        int t, e0;
        do_write(8'h12, 8'hE1);
        do_write(8'h13, 8'hE2);
        do_load(32'h11223344, 8'h10, t);
        tick();
        tick();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks += 5;
            if (md_w[k] !== 8'h00) begin errors++; $display("FAIL abort_memdata[%0d]: got %h required 00", k, md_w[k]); end
            if (rdy_w[k] !== 1'b1) begin errors++; $display("FAIL abort_ready[%0d]: got %b required 1", k, rdy_w[k]); end
            if (busy_w[k] !== 1'b0) begin errors++; $display("FAIL abort_busy[%0d]: got %b required 0", k, busy_w[k]); end
            if (oob_w[k] !== 1'b0) begin errors++; $display("FAIL abort_oob[%0d]: got %b required 0", k, oob_w[k]); end
            if (drop_w[k] !== 1'b0) begin errors++; $display("FAIL abort_drop[%0d]: got %b required 0", k, drop_w[k]); end
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        do_read(8'h10);
        checks++;
        if (md_w[0] !== 8'h11) begin errors++; $display("FAIL abort_keep10: got %h required 11", md_w[0]); end
        do_read(8'h11);
        checks++;
        if (md_w[0] !== 8'h22) begin errors++; $display("FAIL abort_keep11: got %h required 22", md_w[0]); end
        do_read(8'h12);
        checks++;
        if (md_w[0] !== 8'hE1) begin errors++; $display("FAIL abort_skip12: got %h required E1", md_w[0]); end
        do_read(8'h13);
        checks++;
        if (md_w[0] !== 8'hE2) begin errors++; $display("FAIL abort_skip13: got %h required E2", md_w[0]); end
        e0 = edge_n;
        do_load(32'h0BADF00D, 8'h30, t);
        checks++;
        if (t !== e0 + 1) begin errors++; $display("FAIL post_reset_accept: got edge %0d required %0d", t, e0 + 1); end
        wait_idle();
        do_read(8'h30);
        checks++;
        if (md_w[0] !== 8'h0B) begin errors++; $display("FAIL post_reset_load: got %h required 0B", md_w[0]); end
    endtask

    task automatic test_read_write_same();
        memread = 1'b1;
        memwrite = 1'b1;
        adr = 8'h05;
        writedata = 8'h77;
        tick();
        memwrite = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (md_w[k] !== 8'h63) begin errors++; $display("FAIL rbw_old[%0d]: got %h required 63", k, md_w[k]); end
        end
        tick();
        memread = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (md_w[k] !== 8'h77) begin errors++; $display("FAIL rbw_new[%0d]: got %h required 77", k, md_w[k]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            memread   = 1'($urandom_range(0, 1));
            memwrite  = ($urandom_range(0, 3) == 0);
            adr       = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom);
            writedata = 8'($urandom);
            ld_valid  = ($urandom_range(0, 2) == 0);
            ld_word   = $urandom;
            ld_addr   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks += 4;
                if (mmd_known[k]) begin
                    checks++;
                    if (md_w[k] !== mmd[k]) begin errors++; $display("FAIL rnd_memdata[%0d] cyc %0d: got %h required %h", k, n, md_w[k], mmd[k]); end
                end
                if (rdy_w[k] !== (ldq.size() == 0)) begin errors++; $display("FAIL rnd_ready[%0d] cyc %0d: got %b required %b", k, n, rdy_w[k], ldq.size() == 0); end
                if (busy_w[k] !== (ldq.size() != 0)) begin errors++; $display("FAIL rnd_busy[%0d] cyc %0d: got %b required %b", k, n, busy_w[k], ldq.size() != 0); end
                if (oob_w[k] !== moob[k]) begin errors++; $display("FAIL rnd_oob[%0d] cyc %0d: got %b required %b", k, n, oob_w[k], moob[k]); end
                if (drop_w[k] !== mdrop[k]) begin errors++; $display("FAIL rnd_drop[%0d] cyc %0d: got %b required %b", k, n, drop_w[k], mdrop[k]); end
            end
        end
        memread = 1'b0;
        memwrite = 1'b0;
        ld_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        memread = 1'b0;
        memwrite = 1'b0;
        adr = 8'h00;
        writedata = 8'h00;
        ld_valid = 1'b0;
        ld_word = 32'h0;
        ld_addr = 8'h00;
        model_reset();
        test_reset();
        test_load_basic();
        test_back_to_back();
        test_write_drop();
        test_wrap();
        test_oob();
        test_reset_midload();
        test_read_write_same();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
